// File: rtl/priority_encoder.sv
// Registered 4-to-2 priority encoder; D[0] wins, code is 3 - winning index.
// Y and valid come straight from flops, one clock after D is sampled.
module priority_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D,
    output logic [1:0] Y,
    output logic       valid
);

    logic [1:0] y_d;
    logic [1:0] y_q;
    logic       valid_d;
    logic       valid_q;

    // Pick the lowest set bit of D; an empty vector encodes as 0.
    always_comb begin
        y_d     = 2'd0;
        valid_d = |D;
        priority case (1'b1)
            D[0]:    y_d = 2'd3;
            D[1]:    y_d = 2'd2;
            D[2]:    y_d = 2'd1;
            D[3]:    y_d = 2'd0;
            default: y_d = 2'd0;
        endcase
    end

    // Capture the encoding each edge; reset overrides any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign Y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Bench for priority_encoder: directed table, exhaustive sweep, corner
// sequences and random vectors against a behavioural model.
module tb_priority_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] D;
    logic [1:0] Y;
    logic       valid;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] d;
        logic       r;
        logic [1:0] exp_y;
        logic       exp_v;
    } vec_t;

    vec_t vecs [10];

    priority_encoder dut (
        .clk   (clk),
        .rst   (rst),
        .D     (D),
        .Y     (Y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: winner is the lowest-numbered set bit, code = 3 - index.
    function automatic void ref_enc(input logic [3:0] d, input logic r,
                                    output logic [1:0] y, output logic v);
        int idx;
        idx = -1;
        for (int i = 3; i >= 0; i--)
            if (d[i]) idx = i;
        if (r || idx < 0) begin
            y = 2'd0;
            v = 1'b0;
        end else begin
            y = 2'(3 - idx);
            v = 1'b1;
        end
    endfunction

    task automatic check(input string name, input logic [1:0] ey,
                         input logic ev);
        checks++;
        if (Y !== ey || valid !== ev) begin
            errors++;
            $display("FAIL %s: got Y=%0d valid=%0b, expected Y=%0d valid=%0b",
                     name, Y, valid, ey, ev);
        end
    endtask

    // Called at a falling edge: drive, let one rising edge pass, return
    // at the next falling edge.
    task automatic apply(input logic [3:0] d, input logic r);
        D   = d;
        rst = r;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] ey;
        logic       ev;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        D      = 4'b0000;

        vecs[0] = '{4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[1] = '{4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[2] = '{4'b0001, 1'b0, 2'd3, 1'b1};
        vecs[3] = '{4'b0010, 1'b0, 2'd2, 1'b1};
        vecs[4] = '{4'b0100, 1'b0, 2'd1, 1'b1};
        vecs[5] = '{4'b1000, 1'b0, 2'd0, 1'b1};
        vecs[6] = '{4'b0110, 1'b0, 2'd2, 1'b1};
        vecs[7] = '{4'b1100, 1'b0, 2'd1, 1'b1};
        vecs[8] = '{4'b1111, 1'b0, 2'd3, 1'b1};
        vecs[9] = '{4'b1011, 1'b1, 2'd0, 1'b0};

        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].d, vecs[i].r);
            check($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_v);
        end

        for (int i = 0; i < 16; i++) begin
            apply(4'(i), 1'b0);
            ref_enc(4'(i), 1'b0, ey, ev);
            check($sformatf("sweep_d%0d", i), ey, ev);
        end

        // Latency: D changes between edges, Y must wait for the edge.
        apply(4'b1000, 1'b0);
        check("lat_before", 2'd0, 1'b1);
        D = 4'b0001;
        #2;
        check("lat_hold", 2'd0, 1'b1);
        @(negedge clk);
        check("lat_after", 2'd3, 1'b1);

        // Reset in the middle of a steady request stream.
        apply(4'b0010, 1'b0);
        check("mid_pre", 2'd2, 1'b1);
        apply(4'b0010, 1'b1);
        check("mid_rst", 2'd0, 1'b0);
        apply(4'b0010, 1'b0);
        check("mid_post", 2'd2, 1'b1);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] d;
            logic       r;
            d = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 15) == 0);
            apply(d, r);
            ref_enc(d, r, ey, ev);
            check($sformatf("rand%0d_d%0h_r%0b", i, d, r), ey, ev);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
